// File: rtl/vec_pingpong_loader.sv
// Ping-pong input-vector loader: copies one VEC_LEN-pixel vector out of the
// block ROM into the free buffer bank while the consumer reads the other bank.
module vec_pingpong_loader #(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 784,
  parameter int NUM_VEC = 40,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = 15,
  parameter int VIDX_W  = 6,
  parameter int VAW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VIDX_W-1:0] vec_idx,
  output logic              ready,
  output logic              busy,
  output logic              load_done,
  output logic              err,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              rd_valid,
  output logic              rd_bank,
  input  logic [VAW-1:0]    rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_release
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]       state;
  logic [VAW-1:0]   k;
  logic [2:0]       fcnt;
  logic [1:0]       full;
  logic             wr_bank;
  logic             idx_ok, accept, last_k, rel, rd_in_range;

  // (valid, k) travel alongside the ROM read so the write lands with its data
  logic [ROM_LAT:1]          vld_pipe;
  logic [ROM_LAT:1][VAW-1:0] k_pipe;

  logic [DATA_W-1:0] mem [2][VEC_LEN];

  assign idx_ok      = {1'b0, vec_idx} < (VIDX_W+1)'(NUM_VEC);
  // ready is gated by rst so every output reads 0 while reset is held
  assign ready       = rst && (state == S_IDLE) && !full[wr_bank];
  assign accept      = start && ready && idx_ok;
  assign last_k      = (k == VAW'(VEC_LEN-1));
  assign busy        = (state != S_IDLE);
  assign rom_en      = (state == S_ISSUE);
  assign load_done   = (state == S_COMMIT);
  assign rd_valid    = full[rd_bank];
  assign rel         = rd_release && full[rd_bank];
  assign rd_in_range = {1'b0, rd_addr} < (VAW+1)'(VEC_LEN);

  // Load sequencer; rom_addr is a running address that parks on its last value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      k        <= '0;
      fcnt     <= '0;
      rom_addr <= '0;
      wr_bank  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          rom_addr <= ADDR_W'(vec_idx) * ADDR_W'(VEC_LEN);
          k        <= '0;
          state    <= S_ISSUE;
        end
        S_ISSUE: if (last_k) begin
          fcnt  <= '0;
          state <= S_FLUSH;
        end else begin
          k        <= k + VAW'(1);
          rom_addr <= rom_addr + ADDR_W'(1);
        end
        S_FLUSH: if (fcnt == 3'(ROM_LAT-1)) state <= S_COMMIT;
                 else fcnt <= fcnt + 3'd1;
        S_COMMIT: begin
          wr_bank <= ~wr_bank;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reject pulse one cycle after any start that is not accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= start && !accept;
  end

  // Bank occupancy: commit and release never target the same bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= 2'b00;
      rd_bank <= 1'b0;
    end else begin
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (state == S_COMMIT) full[wr_bank] <= 1'b1;
    end
  end

  // ROM_LAT-deep delay line matching the ROM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      k_pipe   <= '0;
    end else begin
      vld_pipe[1] <= rom_en;
      k_pipe[1]   <= k;
      for (int i = 2; i <= ROM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        k_pipe[i]   <= k_pipe[i-1];
      end
    end
  end

  // Buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (vld_pipe[ROM_LAT]) mem[wr_bank][k_pipe[ROM_LAT]] <= rom_data;
  end

  // Registered consumer read; out-of-range addresses read as 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rd_data <= '0;
    else if (rd_in_range) rd_data <= mem[rd_bank][rd_addr];
    else                  rd_data <= '0;
  end

endmodule

// File: tb/tb_vec_pingpong_loader.sv
// Randomised scoreboard bench: three loader configurations run side by side,
// each with its own ROM model, vector-order reference model and monitor.
module tb_vec_pingpong_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ndone = 0;

  typedef struct { int t; int v; } ev_t;

  function automatic ev_t mk(input int tt, input int vv);
    ev_t e;
    e.t = tt;
    e.v = vv;
    return e;
  endfunction

  task automatic chk(input int g, input string nm, input int tt,
                     input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL cfg%0d %s t=%0d got=%0h want=%0h", g, nm, tt, got, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int VL    = (g == 2) ? 784 : 8;
    localparam int NV    = (g == 2) ? 40 : 4;
    localparam int LAT   = (g == 1) ? 3 : 1;
    localparam int VIW   = (g == 2) ? 6 : 3;
    localparam int VAW   = (g == 2) ? 10 : 3;
    localparam int MULT  = (g == 2) ? 7 : 1;
    localparam int NCYC  = (g == 2) ? 5000 : 700;
    localparam int DRAIN = VL + LAT + 12;
    localparam int FIRST = (g == 0) ? 2 : ((g == 1) ? 0 : 39);

    logic           rst, start, ready, busy, load_done, err, rom_en;
    logic           rd_valid, rd_bank, rd_release;
    logic [VIW-1:0] vec_idx;
    logic [14:0]    rom_addr;
    logic [7:0]     rom_data, rd_data;
    logic [VAW-1:0] rd_addr;
    logic [7:0]     rp [LAT];

    vec_pingpong_loader #(
      .DATA_W(8), .VEC_LEN(VL), .NUM_VEC(NV), .ROM_LAT(LAT),
      .ADDR_W(15), .VIDX_W(VIW), .VAW(VAW)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .vec_idx(vec_idx),
      .ready(ready), .busy(busy), .load_done(load_done), .err(err),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_release(rd_release)
    );

    // ROM: data = (addr*MULT)[7:0], LAT cycles after the address
    always @(posedge clk) begin
      rp[0] <= rom_en ? 8'(int'(rom_addr) * MULT) : 8'hA5;
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign rom_data = rp[LAT-1];

    int  t;
    bit  hold = 1'b1;
    ev_t stq[$], aq[$], dq[$], eq[$], rq[$];

    // Monitor: pops expectations whose cycle has come and compares
    initial begin
      ev_t e;
      int  last_a;
      bit  ex;
      last_a = 0;
      forever begin
        @(negedge clk);
        if (hold) last_a = 0;
        else begin
          if (stq.size() > 0 && stq[0].t == t) begin
            e = stq.pop_front();
            chk(g, "status", t, {ready, busy, rd_valid, rd_bank}, e.v);
          end
          ex = aq.size() > 0 && aq[0].t == t;
          if (ex) begin
            e = aq.pop_front();
            chk(g, "rom_addr", t, {rom_en, rom_addr}, {1'b1, 15'(e.v)});
            last_a = e.v;
          end else
            chk(g, "rom_hold", t, {rom_en, rom_addr}, {1'b0, 15'(last_a)});
          ex = dq.size() > 0 && dq[0].t == t;
          if (ex) void'(dq.pop_front());
          if (ex || load_done) chk(g, "load_done", t, load_done, ex);
          ex = eq.size() > 0 && eq[0].t == t;
          if (ex) void'(eq.pop_front());
          if (ex || err) chk(g, "err", t, err, ex);
          if (rq.size() > 0 && rq[0].t == t) begin
            e = rq.pop_front();
            chk(g, "rd_data", t, rd_data, e.v);
          end
        end
      end
    end

    // Stimulus + reference model: q holds loaded vector indices, oldest first
    initial begin
      int q[$];
      bit busy_m, pend_pop, did_rst, force1, st, rel, rdy_m;
      int cur, tstart, tcommit, relcnt, ra, a, v, rst_at;
      busy_m = 0; pend_pop = 0; did_rst = 0; force1 = 0;
      cur = 0; tstart = 0; tcommit = 0; relcnt = 0; ra = 0;
      rst_at = NCYC / 2;
      t = 0;
      rst = 1'b0; start = 1'b0; vec_idx = '0; rd_addr = '0; rd_release = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk(g, "reset_flags", t,
          {busy, ready, load_done, err, rom_en, rd_valid, rd_bank}, 0);
      chk(g, "reset_data", t, {rom_addr, rd_data}, 0);
      rst = 1'b1;
      #1;
      chk(g, "ready_after_reset", t, {ready, busy, rd_valid}, 3'b100);
      hold = 1'b0;

      for (int n = 0; n < NCYC + DRAIN; n++) begin
        @(posedge clk);
        #2;
        t++;
        if (pend_pop) void'(q.pop_front());
        pend_pop = 0;
        if (busy_m && t == tcommit + 1) begin
          q.push_back(cur);
          busy_m = 0;
        end

        if (!did_rst && n >= rst_at && busy_m && t == tstart + 4) begin
          // drop reset in the 4th ISSUE cycle; the partial load must vanish
          hold = 1'b1;
          start = 1'b0;
          rd_release = 1'b0;
          rst = 1'b0;
          #1;
          chk(g, "midload_flags", t,
              {busy, ready, load_done, err, rom_en, rd_valid, rd_bank}, 0);
          chk(g, "midload_data", t, {rom_addr, rd_data}, 0);
          stq.delete(); aq.delete(); dq.delete(); eq.delete(); rq.delete();
          q.delete();
          busy_m = 0; relcnt = 0; did_rst = 1; force1 = 1;
          @(posedge clk);
          #2;
          t++;
          rst = 1'b1;
          #1;
          chk(g, "ready_after_midload", t, {ready, busy, rd_valid}, 3'b100);
          hold = 1'b0;
          continue;
        end

        rdy_m = !busy_m && q.size() < 2;
        stq.push_back(mk(t, int'({rdy_m, busy_m, q.size() > 0, relcnt[0]})));

        st = (n < NCYC) && (n == 0 || force1 || $urandom_range(0, VL/2) == 0 ||
                            (n >= rst_at && !did_rst));
        v  = (n == 0) ? FIRST : (force1 ? 1 : int'($urandom_range(0, NV + 1)));
        if (force1 && st) force1 = 0;
        start   = st;
        vec_idx = VIW'(v);
        if (st) begin
          if (rdy_m && v < NV) begin
            busy_m  = 1;
            cur     = v;
            tstart  = t;
            tcommit = t + VL + LAT + 1;
            for (int j = 0; j < VL; j++) aq.push_back(mk(t + 1 + j, v * VL + j));
            dq.push_back(mk(tcommit, 1));
          end else
            eq.push_back(mk(t + 1, 1));
        end

        rel = (q.size() > 0 && $urandom_range(0, VL) == 0) ||
              $urandom_range(0, 30) == 0 ||
              (n >= NCYC && $urandom_range(0, 3) == 0) ||
              (n >= rst_at && !did_rst && q.size() == 2);
        rd_release = rel;
        if (rel && q.size() > 0) begin
          pend_pop = 1;
          relcnt++;
        end

        a = ra % (1 << VAW);
        rd_addr = VAW'(a);
        if (q.size() > 0)
          rq.push_back(mk(t + 1, (a < VL) ? (((q[0] * VL + a) * MULT) % 256) : 0));
        ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1023)) : ra + 1;
      end

      start = 1'b0;
      rd_release = 1'b0;
      @(posedge clk);
      #2;
      t++;
      @(negedge clk);
      #1;
      chk(g, "scoreboard_empty", t,
          aq.size() + dq.size() + eq.size() + rq.size(), 0);
      chk(g, "midload_reset_done", t, did_rst, 1);
      ndone++;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (ndone < 3 && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    chk(0, "all_configs_done", cyc, ndone, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_pingpong_loader.md
Name: vec_pingpong_loader

Overview:
- Parametrised successor to the single-shot input-vector loader for the FPGA neural-network datapath.
- Fetches one selected input vector (an image of VEC_LEN pixels) from the block-ROM IP into one of two ping-pong buffer banks.
- While one bank fills, the downstream neuron layer reads the other bank through a random-access read port.
- Adds start/done and bank-release handshakes, configurable ROM read latency and index range checking.

Parameters:
- DATA_W, 8, pixel width.
- VEC_LEN, 784, elements per vector.
- NUM_VEC, 40, vectors stored in ROM.
- ROM_LAT, 1, ROM read latency in cycles, 1..4.
- ADDR_W, 15, ROM address width; must satisfy NUM_VEC*VEC_LEN <= 2^ADDR_W.
- VIDX_W, 6, vector index width.
- VAW, 10, buffer address width, ceil(log2(VEC_LEN)).

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- start in 1: load request, sampled when high.
- vec_idx in VIDX_W: vector to load, sampled with start.
- ready out 1: loader idle and write bank empty.
- busy out 1: load in progress.
- load_done out 1: one-cycle pulse when a bank becomes full.
- err out 1: one-cycle pulse on a rejected start.
- rom_en out 1: ROM clock enable / read strobe.
- rom_addr out ADDR_W: ROM address.
- rom_data in DATA_W: ROM data, valid ROM_LAT cycles after its address.
- rd_valid out 1: consumer bank full.
- rd_bank out 1: index of the consumer bank.
- rd_addr in VAW: consumer read address.
- rd_data out DATA_W: registered read data.
- rd_release in 1: consumer finished with the current bank.

Behaviour:
- Reset (rst low, async):
  - FSM goes to IDLE; both banks are empty.
  - wr_bank = 0, rd_bank = 0.
  - All outputs are 0, except ready = 1 after reset deasserts.
  - Buffer RAM contents are not reset.
- State IDLE:
  - ready = (state==IDLE) && !full[wr_bank].
  - Accepted start: start && ready && vec_idx < NUM_VEC. Latch base = vec_idx*VEC_LEN, clear k, go to ISSUE, assert busy.
  - Rejected start: start && !(ready && vec_idx<NUM_VEC). Pulse err the next cycle; nothing else changes.
  - start while busy is rejected the same way.
- State ISSUE:
  - Lasts exactly VEC_LEN cycles.
  - rom_en = 1, rom_addr = base + k, k counts 0..VEC_LEN-1.
  - Address is formed by incrementing a running register, not by a multiply per cycle.
  - After the k = VEC_LEN-1 cycle, go to FLUSH.
- Write pipeline:
  - A ROM_LAT-deep shift register carries (valid, k).
  - When the delayed valid is high, write rom_data into bank wr_bank at address k.
- State FLUSH:
  - rom_en = 0.
  - Stays ROM_LAT cycles until the pipeline drains, then go to COMMIT.
- State COMMIT:
  - Lasts 1 cycle.
  - Sets full[wr_bank], pulses load_done, toggles wr_bank, deasserts busy, returns to IDLE.
- Latency:
  - start sampled at edge 0.
  - rom_en high cycles 1..VEC_LEN.
  - load_done high in cycle VEC_LEN+ROM_LAT+1.
- Consumer side:
  - rd_valid = full[rd_bank].
  - rd_data registered: value at bank rd_bank, address rd_addr, appears 1 cycle after rd_addr.
  - rd_addr >= VEC_LEN returns 0.
  - rd_data is undefined-but-stable when rd_valid = 0; the bench must not check it.
- Release:
  - rd_release with rd_valid = 1 clears full[rd_bank] and toggles rd_bank at that edge.
  - rd_release with rd_valid = 0 is ignored.
- Simultaneous events:
  - COMMIT to one bank and release of the other bank in the same cycle: both take effect.
  - Start in the cycle after COMMIT is accepted only if the new wr_bank is empty.
- Both banks full: ready = 0 until a release.
  - A release followed by start refills the released bank; ordering is preserved.
- Reset mid-load:
  - Aborts the load; the partially written bank stays empty.
  - No load_done is issued.
- rom_addr holds its last value when rom_en = 0.

Test Plan:
1. Config VEC_LEN=8, NUM_VEC=4, ROM_LAT=1; ROM model returns rom_data = addr[7:0].
   - start with vec_idx=2 -> rom_addr 16..23 on cycles 1..8.
   - load_done on cycle 10; rd_valid=1 with rd_bank=0.
   - Reading rd_addr 0..7 gives 16..23, each 1 cycle later.
2. Ping-pong: load vec 1 then vec 3 without release.
   - Bank0 holds 8..15, bank1 holds 24..31; ready=0.
   - A third start pulses err.
   - rd_release -> rd_bank=1, rd_valid=1, data 24..31.
3. Rejects:
   - vec_idx=4 -> err pulse, no rom_en.
   - start during ISSUE -> err pulse, the ongoing load is unaffected.
4. ROM_LAT=3 with the same ROM model: load vec 0.
   - Bank holds 0..7 exactly.
   - load_done on cycle 12.
5. Reset mid-load: drop rst at cycle 4 of ISSUE.
   - All outputs are 0 and rd_valid=0.
   - After release of reset, ready=1 and a fresh load of vec 1 completes correctly.
6. Default parameters, ROM model = (addr*7)[7:0]: load vec 39.
   - rom_addr reaches 31359 and no higher.
   - All 784 words match; rd_addr 800 returns 0.
